mips_mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the 32-bit MIPS datapath. Sequences fetch/decode/execute/memory/writeback.

---
 rtl/mips_mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the 32-bit MIPS datapath (fetch/decode/execute/memory/writeback).
// Define MC_CTRL_BRANCH_EN to add BEQ support; otherwise BEQ decodes as illegal.
module mips_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_mem_ready,
    input  logic             i_zero,
    output logic             o_alu_src,
    output logic [3:0]       o_alu_ctrl,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic             o_pc_src,
    output logic             o_mem_rd,
    output logic             o_mem_we,
    output logic             o_reg_we,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_illegal,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t           state_q;
    logic [5:0]       opcode_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] retired_q;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R:                   ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                                         (fn == FN_OR)  || (fn == FN_SLT);
            OP_LW, OP_SW, OP_ADDI:  ok = 1'b1;
`ifdef MC_CTRL_BRANCH_EN
            OP_BEQ:                 ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] r_alu_ctrl(input logic [5:0] fn);
        logic [3:0] c;
        case (fn)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    // State sequencing, instruction latches and retire counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= 6'd0;
            funct_q   <= 6'd0;
            retired_q <= '0;
        end else begin
            case (state_q)
                IDLE:   state_q <= FETCH;
                FETCH:  if (i_mem_ready) state_q <= DECODE;
                DECODE: begin
                    opcode_q <= i_opcode;
                    funct_q  <= i_funct;
                    state_q  <= is_legal(i_opcode, i_funct) ? EXEC : FETCH;
                end
                EXEC: begin
                    case (opcode_q)
                        OP_LW, OP_SW:  state_q <= MEM;
                        OP_R, OP_ADDI: state_q <= WB;
                        default: begin
                            // Only BEQ reaches here; it retires straight from EXEC
                            state_q   <= FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    endcase
                end
                MEM: begin
                    if (i_mem_ready) begin
                        if (opcode_q == OP_LW) begin
                            state_q <= WB;
                        end else begin
                            state_q   <= FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    end
                end
                WB: begin
                    state_q   <= FETCH;
                    retired_q <= retired_q + CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode from the state register so reset clears them immediately
    always_comb begin
        o_alu_src    = 1'b0;
        o_alu_ctrl   = 4'b0000;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_src     = 1'b0;
        o_mem_rd     = 1'b0;
        o_mem_we     = 1'b0;
        o_reg_we     = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                o_mem_rd = 1'b1;
                o_ir_we  = i_mem_ready;
                o_pc_we  = i_mem_ready;
            end
            DECODE: o_illegal = !is_legal(i_opcode, i_funct);
            EXEC: begin
                case (opcode_q)
                    OP_R: o_alu_ctrl = r_alu_ctrl(funct_q);
`ifdef MC_CTRL_BRANCH_EN
                    OP_BEQ: begin
                        o_alu_ctrl = ALU_SUB;
                        o_pc_we    = i_zero;
                        o_pc_src   = i_zero;
                    end
`endif
                    default: begin
                        o_alu_src  = 1'b1;
                        o_alu_ctrl = ALU_ADD;
                    end
                endcase
            end
            MEM: begin
                // Address operands stay stable for the whole access
                o_alu_src  = 1'b1;
                o_alu_ctrl = ALU_ADD;
                o_mem_rd   = (opcode_q == OP_LW);
                o_mem_we   = (opcode_q != OP_LW);
            end
            WB: begin
                o_reg_we     = 1'b1;
                o_reg_dst    = (opcode_q == OP_R);
                o_mem_to_reg = (opcode_q == OP_LW);
            end
            default: ;
        endcase
    end

`ifndef MC_CTRL_BRANCH_EN
    logic unused_zero;
    assign unused_zero = i_zero;
`endif

    assign o_state   = 3'(state_q);
    assign o_retired = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl; one task per scenario, cycle-scripted from FETCH.
module tb_mips_mc_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic [5:0]  i_opcode;
    logic [5:0]  i_funct;
    logic        i_mem_ready;
    logic        i_zero;
    logic        o_alu_src;
    logic [3:0]  o_alu_ctrl;
    logic        o_ir_we, o_pc_we, o_pc_src, o_mem_rd, o_mem_we;
    logic        o_reg_we, o_reg_dst, o_mem_to_reg, o_illegal;
    logic [2:0]  o_state;
    logic [31:0] o_retired;

    int checks;
    int failures;
    logic [31:0] exp_ret;

    mips_mc_ctrl #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_mem_ready(i_mem_ready), .i_zero(i_zero),
        .o_alu_src(o_alu_src), .o_alu_ctrl(o_alu_ctrl), .o_ir_we(o_ir_we),
        .o_pc_we(o_pc_we), .o_pc_src(o_pc_src), .o_mem_rd(o_mem_rd), .o_mem_we(o_mem_we),
        .o_reg_we(o_reg_we), .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg),
        .o_illegal(o_illegal), .o_state(o_state), .o_retired(o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // {state, alu_src, alu_ctrl, ir_we, pc_we, pc_src, mem_rd, mem_we, reg_we, reg_dst, mem_to_reg, illegal}
    logic [16:0] obs;
    assign obs = {o_state, o_alu_src, o_alu_ctrl, o_ir_we, o_pc_we, o_pc_src, o_mem_rd,
                  o_mem_we, o_reg_we, o_reg_dst, o_mem_to_reg, o_illegal};

    function automatic logic [16:0] mk(input logic [2:0] st, input logic src,
                                       input logic [3:0] ctrl, input logic [8:0] fl);
        return {st, src, ctrl, fl};
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0; i_mem_ready = 1'b0; i_opcode = 6'd0; i_funct = 6'd0; i_zero = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        checks++;
        if (obs !== 17'd0 || o_retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h ret=%0d exp=%h ret=0", obs, o_retired, 17'd0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        #1;
        checks++;
        if (obs !== mk(3'd1, 1'b0, 4'd0, 9'b000100000) || o_retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_fetch got=%h ret=%0d exp=%h ret=0", obs, o_retired,
                     mk(3'd1, 1'b0, 4'd0, 9'b000100000));
        end
        @(negedge i_clk);
    endtask

    task automatic test_add();
        logic [16:0] ev [4];
        ev = '{mk(3'd1, 1'b0, 4'b0000, 9'b110100000), mk(3'd2, 1'b0, 4'b0000, 9'b0),
               mk(3'd3, 1'b0, 4'b0010, 9'b0),          mk(3'd5, 1'b0, 4'b0000, 9'b000001100)};
        i_opcode = 6'b000000; i_funct = 6'b100000;
        for (int k = 0; k < 4; k++) begin
            i_mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== ev[k]) begin
                failures++;
                $display("FAIL add step%0d got=%h exp=%h", k, obs, ev[k]);
            end
            @(negedge i_clk);
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (o_retired !== exp_ret) begin
            failures++;
            $display("FAIL add_retired got=%0d exp=%0d", o_retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] ev [7];
        logic        rdy [7];
        ev = '{mk(3'd1, 1'b0, 4'b0000, 9'b110100000), mk(3'd2, 1'b0, 4'b0000, 9'b0),
               mk(3'd3, 1'b1, 4'b0010, 9'b0),
               mk(3'd4, 1'b1, 4'b0010, 9'b000100000), mk(3'd4, 1'b1, 4'b0010, 9'b000100000),
               mk(3'd4, 1'b1, 4'b0010, 9'b000100000), mk(3'd5, 1'b0, 4'b0000, 9'b000001010)};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i_opcode = 6'b100011; i_funct = 6'b000000;
        for (int k = 0; k < 7; k++) begin
            i_mem_ready = rdy[k];
            #1;
            checks++;
            if (obs !== ev[k]) begin
                failures++;
                $display("FAIL lw step%0d got=%h exp=%h", k, obs, ev[k]);
            end
            @(negedge i_clk);
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (o_retired !== exp_ret || o_state !== 3'd1) begin
            failures++;
            $display("FAIL lw_retired got=%0d st=%0d exp=%0d st=1", o_retired, o_state, exp_ret);
        end
    endtask

    task automatic test_sw();
        logic [16:0] ev [5];
        logic        rdy [5];
        ev = '{mk(3'd1, 1'b0, 4'b0000, 9'b000100000), mk(3'd1, 1'b0, 4'b0000, 9'b110100000),
               mk(3'd2, 1'b0, 4'b0000, 9'b0),          mk(3'd3, 1'b1, 4'b0010, 9'b0),
               mk(3'd4, 1'b1, 4'b0010, 9'b000010000)};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        i_opcode = 6'b101011; i_funct = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            i_mem_ready = rdy[k];
            #1;
            checks++;
            if (obs !== ev[k]) begin
                failures++;
                $display("FAIL sw step%0d got=%h exp=%h", k, obs, ev[k]);
            end
            @(negedge i_clk);
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (o_retired !== exp_ret || o_state !== 3'd1) begin
            failures++;
            $display("FAIL sw_retired got=%0d st=%0d exp=%0d st=1", o_retired, o_state, exp_ret);
        end
    endtask

    task automatic test_addi();
        logic [16:0] ev [4];
        ev = '{mk(3'd1, 1'b0, 4'b0000, 9'b110100000), mk(3'd2, 1'b0, 4'b0000, 9'b0),
               mk(3'd3, 1'b1, 4'b0010, 9'b0),          mk(3'd5, 1'b0, 4'b0000, 9'b000001000)};
        i_opcode = 6'b001000; i_funct = 6'b101010;
        for (int k = 0; k < 4; k++) begin
            i_mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== ev[k]) begin
                failures++;
                $display("FAIL addi step%0d got=%h exp=%h", k, obs, ev[k]);
            end
            @(negedge i_clk);
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (o_retired !== exp_ret) begin
            failures++;
            $display("FAIL addi_retired got=%0d exp=%0d", o_retired, exp_ret);
        end
    endtask

    task automatic test_r_funct();
        logic [5:0] fn [4];
        logic [3:0] ac [4];
        fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ac = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
        i_mem_ready = 1'b1;
        i_opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            i_funct = fn[i];
            @(negedge i_clk);
            @(negedge i_clk);
            #1;
            checks++;
            if (obs !== mk(3'd3, 1'b0, ac[i], 9'b0)) begin
                failures++;
                $display("FAIL rfunct_%0d got=%h exp=%h", i, obs, mk(3'd3, 1'b0, ac[i], 9'b0));
            end
            @(negedge i_clk);
            @(negedge i_clk);
            exp_ret = exp_ret + 32'd1;
        end
        checks++;
        if (o_retired !== exp_ret) begin
            failures++;
            $display("FAIL rfunct_retired got=%0d exp=%0d", o_retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op [3];
        logic [5:0] fn [3];
        int n;
        op = '{6'b111111, 6'b000000, 6'b000100};
        fn = '{6'b100000, 6'b000000, 6'b000000};
`ifdef MC_CTRL_BRANCH_EN
        n = 2;
`else
        n = 3;
`endif
        i_mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            i_opcode = op[i]; i_funct = fn[i];
            @(negedge i_clk);
            #1;
            checks++;
            if (obs !== mk(3'd2, 1'b0, 4'd0, 9'b000000001)) begin
                failures++;
                $display("FAIL illegal_dec%0d got=%h exp=%h", i, obs, mk(3'd2, 1'b0, 4'd0, 9'b000000001));
            end
            @(negedge i_clk);
            #1;
            checks++;
            if (obs !== mk(3'd1, 1'b0, 4'd0, 9'b110100000) || o_retired !== exp_ret) begin
                failures++;
                $display("FAIL illegal_next%0d got=%h ret=%0d exp=%h ret=%0d", i, obs, o_retired,
                         mk(3'd1, 1'b0, 4'd0, 9'b110100000), exp_ret);
            end
        end
    endtask

`ifdef MC_CTRL_BRANCH_EN
    task automatic test_beq();
        logic       z [2];
        logic [8:0] fl [2];
        z  = '{1'b1, 1'b0};
        fl = '{9'b011000000, 9'b000000000};
        i_mem_ready = 1'b1;
        i_opcode = 6'b000100; i_funct = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            i_zero = z[i];
            @(negedge i_clk);
            @(negedge i_clk);
            #1;
            checks++;
            if (obs !== mk(3'd3, 1'b0, 4'b0110, fl[i])) begin
                failures++;
                $display("FAIL beq_exec%0d got=%h exp=%h", i, obs, mk(3'd3, 1'b0, 4'b0110, fl[i]));
            end
            @(negedge i_clk);
            exp_ret = exp_ret + 32'd1;
            checks++;
            if (o_state !== 3'd1 || o_retired !== exp_ret) begin
                failures++;
                $display("FAIL beq_done%0d st=%0d ret=%0d exp st=1 ret=%0d", i, o_state, o_retired, exp_ret);
            end
        end
        i_zero = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_sw();
        i_mem_ready = 1'b1;
        i_opcode = 6'b101011; i_funct = 6'b000000;
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== mk(3'd4, 1'b1, 4'b0010, 9'b000010000)) begin
            failures++;
            $display("FAIL midsw_mem got=%h exp=%h", obs, mk(3'd4, 1'b1, 4'b0010, 9'b000010000));
        end
        i_rst_n = 1'b0;
        #1;
        exp_ret = 32'd0;
        checks++;
        if (obs !== 17'd0 || o_mem_we !== 1'b0 || o_retired !== exp_ret) begin
            failures++;
            $display("FAIL midsw_reset got=%h we=%b ret=%0d exp=0 we=0 ret=0", obs, o_mem_we, o_retired);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        #1;
        checks++;
        if (o_state !== 3'd1 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL midsw_restart st=%0d we=%b exp st=1 we=0", o_state, o_mem_we);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_ret = 32'd0;
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_addi();
        test_r_funct();
        test_illegal();
`ifdef MC_CTRL_BRANCH_EN
        test_beq();
`endif
        test_reset_mid_sw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
